// File: rtl/jk_cmd_sequencer.sv
// Command FIFO feeding a two-state sequencer that drives J/K of a downstream
// JK flip-flop and tracks its expected state. Optional checker: JK_SEQ_CHECK_EN.
module jk_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     flush,
  output logic                     j,
  output logic                     k,
  output logic                     q_exp,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef JK_SEQ_CHECK_EN
  ,
  input  logic                     q_obs,
  output logic                     chk_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 2 + LEN_W;

  typedef enum logic {
    IDLE,
    DRIVE
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             q_exp_q, q_exp_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [EW-1:0]    mem_q [DEPTH];

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  logic [1:0]       head_op;
  logic [LEN_W-1:0] head_len;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = rst_n & ~full & ~flush;
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];
  assign head_op   = head[EW-1 -: 2];
  assign head_len  = head[LEN_W-1:0];

  // Sequencer: a pop is only ever taken from entries already stored, so a
  // command pushed this edge becomes visible on j/k one edge later.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    j_d     = j_q;
    k_d     = k_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          {j_d, k_d} = head_op;
          rem_d      = head_len;
          state_d    = DRIVE;
        end else begin
          j_d = 1'b0;
          k_d = 1'b0;
        end
      end
      DRIVE: begin
        if (rem_q != '0) begin
          rem_d = rem_q - LEN_W'(1);
        end else if (!empty) begin
          pop        = 1'b1;
          {j_d, k_d} = head_op;
          rem_d      = head_len;
        end else begin
          j_d     = 1'b0;
          k_d     = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      pop     = 1'b0;
      state_d = IDLE;
      rem_d   = '0;
      j_d     = 1'b0;
      k_d     = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    q_exp_d = q_exp_q;
    unique case ({j_q, k_q})
      2'b01:   q_exp_d = 1'b0;
      2'b10:   q_exp_d = 1'b1;
      2'b11:   q_exp_d = ~q_exp_q;
      default: q_exp_d = q_exp_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      q_exp_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      j_q      <= j_d;
      k_q      <= k_d;
      q_exp_q  <= q_exp_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_len};
  end

  assign j          = j_q;
  assign k          = k_q;
  assign q_exp      = q_exp_q;
  assign busy       = (state_q == DRIVE) | ~empty;
  assign fifo_level = count_q;

`ifdef JK_SEQ_CHECK_EN
  logic chk_err_q, chk_err_d;

  always_comb begin
    chk_err_d = chk_err_q | (q_obs != q_exp_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else        chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: constant vector table, directed
// corner sequences and random traffic against a queue-based reference model.
module tb_jk_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LEN_W = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;
  logic       flush;
  logic       j;
  logic       k;
  logic       q_exp;
  logic       busy;
  logic [2:0] fifo_level;
`ifdef JK_SEQ_CHECK_EN
  logic       q_obs;
  logic       chk_err;
  bit         q_obs_flip;
`endif

  jk_cmd_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .flush      (flush),
    .j          (j),
    .k          (k),
    .q_exp      (q_exp),
    .busy       (busy),
    .fifo_level (fifo_level)
`ifdef JK_SEQ_CHECK_EN
    ,
    .q_obs      (q_obs),
    .chk_err    (chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending commands in a queue, active command as a plain
  // count of drive cycles still to run (0 = nothing active).
  typedef struct packed {
    bit [1:0] op;
    bit [3:0] len;
  } cmd_t;

  cmd_t m_q[$];
  int   m_left;
  bit   mj, mk, mq;

  typedef struct {
    bit       v;
    bit [1:0] op;
    bit [3:0] len;
    bit       fl;
    bit       ej;
    bit       ek;
    bit       eq;
    bit       eb;
    int       el;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(input bit fl);
    return (m_q.size() < DEPTH) && !fl;
  endfunction

  function automatic bit m_busy();
    return (m_left > 0) || (m_q.size() > 0);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_left = 0;
    mj = 0; mk = 0; mq = 0;
  endtask

  task automatic model_step(input bit v, input bit [1:0] op, input bit [3:0] len, input bit fl);
    bit   accept;
    cmd_t c;
    accept = v && m_ready(fl);
    case ({mj, mk})
      2'b01: mq = 0;
      2'b10: mq = 1;
      2'b11: mq = !mq;
      default: ;
    endcase
    if (fl) begin
      m_q.delete();
      m_left = 0;
      mj = 0; mk = 0;
    end else begin
      if (m_left > 1) begin
        m_left--;
      end else if (m_q.size() > 0) begin
        c = m_q.pop_front();
        {mj, mk} = c.op;
        m_left = int'(c.len) + 1;
      end else begin
        m_left = 0;
        mj = 0; mk = 0;
      end
      if (accept) begin
        c.op = op; c.len = len;
        m_q.push_back(c);
      end
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit v, input bit [1:0] op, input bit [3:0] len, input bit fl,
                      output bit acc);
    cmd_valid = v; cmd_op = op; cmd_len = len; flush = fl;
    #1;
    chk("cmd_ready", cmd_ready, m_ready(fl));
    acc = v && cmd_ready;
    @(posedge clk);
    model_step(v, op, len, fl);
    @(negedge clk);
    chk("outs", {j, k, q_exp, busy, fifo_level},
        {mj, mk, mq, m_busy(), 3'(m_q.size())});
`ifdef JK_SEQ_CHECK_EN
    q_obs = mq ^ q_obs_flip;
`endif
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 2'b00, 4'd0, 0, acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; flush = 1'b0;
    #1;
    chk("reset_outs", {j, k, q_exp, busy, fifo_level, cmd_ready}, 32'd0);
`ifdef JK_SEQ_CHECK_EN
    chk("reset_chk_err", chk_err, 1'b0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
`ifdef JK_SEQ_CHECK_EN
    q_obs = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    bit q0;
    int cnt;
    int rejected;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; flush = 1'b0;
`ifdef JK_SEQ_CHECK_EN
    q_obs = 1'b0; q_obs_flip = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    do_reset();

    // Set for exactly one cycle.
    step(1, 2'b10, 4'd0, 0, acc);
    idle(1);
    chk("r032_jk", {j, k}, 2'b10);
    cnt = 0;
    for (int i = 0; i < 8 && j; i++) begin
      cnt++;
      idle(1);
    end
    chk("r032_cycles", cnt, 1);
    chk("r032_q", q_exp, 1'b1);

    // Back-to-back commands: {v,op,len,fl, expected j,k,q,busy,level}.
    tbl[0] = '{1, 2'b00, 4'd0, 0, 0, 0, 0, 1, 1};
    tbl[1] = '{1, 2'b10, 4'd0, 0, 0, 0, 0, 1, 1};
    tbl[2] = '{1, 2'b00, 4'd0, 0, 1, 0, 0, 1, 1};
    tbl[3] = '{1, 2'b01, 4'd0, 0, 0, 0, 1, 1, 1};
    tbl[4] = '{1, 2'b11, 4'd1, 0, 0, 1, 1, 1, 1};
    tbl[5] = '{0, 2'b00, 4'd0, 0, 1, 1, 0, 1, 0};
    tbl[6] = '{0, 2'b00, 4'd0, 0, 1, 1, 1, 1, 0};
    tbl[7] = '{0, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].op, tbl[i].len, tbl[i].fl, acc);
      chk($sformatf("tbl[%0d]", i), {j, k, q_exp, busy, fifo_level},
          {tbl[i].ej, tbl[i].ek, tbl[i].eq, tbl[i].eb, 3'(tbl[i].el)});
    end

    // Toggle four times returns to the start value.
    q0 = q_exp;
    step(1, 2'b11, 4'd3, 0, acc);
    idle(1);
    cnt = 0;
    for (int i = 0; i < 10 && j && k; i++) begin
      cnt++;
      idle(1);
    end
    chk("r033_cycles", cnt, 4);
    chk("r033_q", q_exp, q0);

    // Fill while a 16-cycle command drives; fifth push waits for the first pop.
    @(negedge clk);
    do_reset();
    step(1, 2'b11, 4'd15, 0, acc);
    for (int i = 0; i < 4; i++) step(1, 2'(i), 4'd0, 0, acc);
    chk("r035_level", fifo_level, 3'd4);
    chk("r035_ready_full", cmd_ready, 1'b0);
    rejected = 0;
    acc = 0;
    for (int i = 0; i < 30 && !acc; i++) begin
      step(1, 2'b10, 4'd1, 0, acc);
      if (!acc) rejected++;
    end
    chk("r035_accepted", acc, 1'b1);
    chk("r035_wait", rejected, 13);
    idle(12);
    chk("r035_drain", {busy, fifo_level}, 4'd0);

    // Flush at the third drive cycle with a command queued behind.
    @(negedge clk);
    do_reset();
    step(1, 2'b11, 4'd7, 0, acc);
    step(1, 2'b10, 4'd2, 0, acc);
    idle(2);
    step(0, 2'b00, 4'd0, 1, acc);
    chk("r036_after_flush", {j, k, busy, fifo_level}, 6'd0);
    idle(3);
    chk("r036_stays_idle", {j, k, busy, fifo_level}, 6'd0);

    // Checker sticky error, then reset in the middle of a command.
    step(1, 2'b11, 4'd9, 0, acc);
    step(1, 2'b01, 4'd1, 0, acc);
    idle(2);
`ifdef JK_SEQ_CHECK_EN
    chk("r037_chk_clean", chk_err, 1'b0);
    q_obs_flip = 1'b1;
    idle(1);
    q_obs_flip = 1'b0;
    idle(1);
    chk("r037_chk_set", chk_err, 1'b1);
    idle(2);
    chk("r037_chk_sticky", chk_err, 1'b1);
`endif
    #2;
    do_reset();
    idle(2);
    chk("r037_after_reset", {j, k, busy, fifo_level}, 6'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit       v;
      bit [1:0] op;
      bit [3:0] len;
      bit       fl;
      v   = ($urandom_range(0, 9) < 6);
      op  = 2'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      fl  = ($urandom_range(0, 49) == 0);
      step(v, op, len, fl, acc);
    end
`ifdef JK_SEQ_CHECK_EN
    chk("random_chk_err", chk_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth (power of 2, at least 2).
REQ-002 SHALL have parameter LEN_W, default 4, width of the command repeat field.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit, command offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit, command accepted when cmd_valid and cmd_ready are both high at a clock edge.
REQ-007 SHALL have port cmd_op, input, 2 bits, {J,K}: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-008 SHALL have port cmd_len, input, LEN_W bits, repeat count; the command drives for cmd_len+1 cycles.
REQ-009 SHALL have port flush, input, 1 bit, synchronous abort.
REQ-010 SHALL have port j, output, 1 bit, registered J drive to the downstream JK flip-flop.
REQ-011 SHALL have port k, output, 1 bit, registered K drive to the downstream JK flip-flop.
REQ-012 SHALL have port q_exp, output, 1 bit, modelled flip-flop state.
REQ-013 SHALL have port busy, output, 1 bit, high when the FSM is in DRIVE or the FIFO is non-empty.
REQ-014 SHALL have port fifo_level, output, clog2(DEPTH)+1 bits, current FIFO occupancy.

Function
REQ-015 SHALL buffer accepted commands in FIFO order; cmd_ready = rst_n AND NOT full AND NOT flush.
REQ-016 SHALL implement FSM states IDLE and DRIVE with a remaining-cycle counter rem of LEN_W bits.
REQ-017 SHALL in IDLE, with the FIFO non-empty, pop the head, load {j,k} <= op and rem <= len, and go to DRIVE; with the FIFO empty, hold j = k = 0.
REQ-018 SHALL in DRIVE decrement rem while rem != 0 and hold j/k.
REQ-019 SHALL in DRIVE at rem == 0 pop the next command if one is present, with no bubble cycle; otherwise set j = k = 0 and return to IDLE.
REQ-020 SHALL give latency of one edge: a command accepted at edge N into an empty FIFO while IDLE appears on j/k after edge N+1.
REQ-021 SHALL, on a push and pop at the same edge, apply both and leave fifo_level unchanged; a push while full is impossible, because cmd_ready is low.
REQ-022 SHALL update q_exp each edge from the current j/k: 00 keep, 01 to 0, 10 to 1, 11 invert.
REQ-023 SHALL make q_exp match the q of a downstream JK flip-flop reset at the same time.
REQ-024 SHALL give flush priority over pop and push: empty the FIFO, go to IDLE, j = k = 0 at the next edge, and leave q_exp updating per REQ-022.
REQ-025 SHALL allow rem to count the full LEN_W range, so cmd_len = all-ones gives 2^LEN_W drive cycles with no wrap.

Reset
REQ-026 SHALL, while rst_n is low, immediately force: FIFO empty, fifo_level = 0, state IDLE, rem = 0, j = 0, k = 0, q_exp = 0, busy = 0, cmd_ready = 0.
REQ-027 SHALL, on rst_n asserted mid-command, discard the command in flight and all queued commands.
REQ-028 SHALL resume normal operation at the first clock edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with JK_SEQ_CHECK_EN defined, add input q_obs (1 bit) and output chk_err (1 bit).
REQ-030 SHALL, with JK_SEQ_CHECK_EN defined, set chk_err sticky-high at any edge where q_obs != q_exp; only reset clears it.
REQ-031 SHALL, without JK_SEQ_CHECK_EN, omit q_obs and chk_err entirely, with no other behavioural change.

Verification
REQ-032 SHALL cover: after reset, push op=10 len=0 -> j=1,k=0 for exactly 1 cycle, then 00; q_exp=1.
REQ-033 SHALL cover: push op=11 len=3 -> j=k=1 for 4 cycles; q_exp toggles 4 times and ends at its start value.
REQ-034 SHALL cover: push 00/0, 10/0, 00/0, 01/0, 11/1 back-to-back -> j/k sequence 00,10,00,01,11,11 with no bubbles; q_exp ends 0.
REQ-035 SHALL cover: with DEPTH=4, push 5 commands while the first drives len=15 -> cmd_ready low at fifo_level=4; the fifth is accepted after the first pop.
REQ-036 SHALL cover: flush during op=11 len=7 at cycle 3 -> j=k=0 at the next edge, fifo_level=0, busy=0.
REQ-037 SHALL cover: rst_n low mid-command -> all outputs 0 immediately; with JK_SEQ_CHECK_EN, forcing q_obs opposite to q_exp for one cycle -> chk_err=1 and held until reset.
